sysbus_arbiter: RTL and testbench

Shares the single system-bus master port between the instruction-fetch unit and the data-memory unit of the core. It accepts one cache-line transaction at a time from either requester, drives the bus request/tag/data handshake, counts response or write-data beats, and routes read beats back to the requester that owns the transaction. When both requesters are pending, grants alternate between them so neither side starves.

---
 rtl/sysbus_arbiter.sv | 125 ++++++++++++
 tb/tb_sysbus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one system-bus master port between instruction fetch and data memory.
// Ports:
//   clk, reset (async, active-low)
//   if_*   : fetch requester (line reads only): request/grant, response beats
//   dm_*   : data requester (line reads and writes): request/grant, write-beat handshake,
//            response beats, write-done pulse
//   bus_*  : system-bus master side: request cycle/ack/address-or-data/tag, response cycle/ack/data/tag
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_req_valid,
    input  logic [BUS_DATA_WIDTH-1:0] if_req_addr,
    output logic                      if_grant,
    output logic                      if_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] if_resp_data,
    output logic                      if_resp_last,
    input  logic                      dm_req_valid,
    input  logic                      dm_req_write,
    input  logic [BUS_DATA_WIDTH-1:0] dm_req_addr,
    input  logic [BUS_DATA_WIDTH-1:0] dm_wdata,
    output logic                      dm_wdata_ready,
    output logic                      dm_grant,
    output logic                      dm_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] dm_resp_data,
    output logic                      dm_resp_last,
    output logic                      dm_done,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BUS_TAG_WIDTH-1:0] RD_TAG =
        (BUS_TAG_WIDTH'(`SYSBUS_READ) << 8) | (BUS_TAG_WIDTH'(`SYSBUS_MEMORY) << 12);
    localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG =
        (BUS_TAG_WIDTH'(`SYSBUS_WRITE) << 8) | (BUS_TAG_WIDTH'(`SYSBUS_MEMORY) << 12);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic                      own_dm;
    logic                      last_dm;
    logic                      wr;
    logic [BUS_DATA_WIDTH-1:0] addr;
    logic                      in_req, in_wd, in_resp, last_cnt, pick_dm;
    // Only one transaction is ever outstanding, so the response tag carries no routing information.
    logic                      unused_tag;

    assign unused_tag = ^bus_resptag;
    assign in_req     = state == REQ;
    assign in_wd      = state == WDATA;
    assign in_resp    = state == RESP;
    assign last_cnt   = cnt == CW'(BEATS - 1);
    // On contention the side that did not own the previous transaction wins.
    assign pick_dm    = dm_req_valid && (!if_req_valid || !last_dm);

    assign bus_reqcyc     = in_req || in_wd;
    assign bus_req        = in_wd ? dm_wdata : in_req ? addr : '0;
    assign bus_reqtag     = !bus_reqcyc ? '0 : wr ? WR_TAG : RD_TAG;
    assign bus_respack    = in_resp && bus_respcyc;
    assign if_grant       = in_req && bus_reqack && !own_dm;
    assign dm_grant       = in_req && bus_reqack && own_dm;
    assign if_resp_valid  = bus_respack && !own_dm;
    assign dm_resp_valid  = bus_respack && own_dm;
    assign if_resp_last   = if_resp_valid && last_cnt;
    assign dm_resp_last   = dm_resp_valid && last_cnt;
    assign if_resp_data   = if_resp_valid ? bus_resp : '0;
    assign dm_resp_data   = dm_resp_valid ? bus_resp : '0;
    assign dm_wdata_ready = in_wd && bus_reqack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            own_dm  <= 1'b0;
            last_dm <= 1'b0;
            wr      <= 1'b0;
            addr    <= '0;
            dm_done <= 1'b0;
        end else begin
            dm_done <= dm_wdata_ready && last_cnt;
            case (state)
                IDLE: if (if_req_valid || dm_req_valid) begin
                    own_dm <= pick_dm;
                    wr     <= pick_dm && dm_req_write;
                    addr   <= pick_dm ? dm_req_addr : if_req_addr;
                    state  <= REQ;
                end
                REQ: if (bus_reqack) begin
                    last_dm <= own_dm;
                    cnt     <= '0;
                    state   <= wr ? WDATA : RESP;
                end
                WDATA: if (bus_reqack) begin
                    cnt   <= last_cnt ? '0 : cnt + 1'b1;
                    state <= last_cnt ? IDLE : WDATA;
                end
                RESP: if (bus_respcyc) begin
                    cnt   <= last_cnt ? '0 : cnt + 1'b1;
                    state <= last_cnt ? IDLE : RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: self-checking bench for sysbus_arbiter (cycle table plus hand-written bus sequences).
module tb_sysbus_arbiter;
    localparam int BEATS = 8;
    localparam logic [12:0] RD = 13'h1100;
    localparam logic [12:0] WR = 13'h1000;

    logic        clk, reset;
    logic        if_req_valid, if_grant, if_resp_valid, if_resp_last;
    logic [63:0] if_req_addr, if_resp_data;
    logic        dm_req_valid, dm_req_write, dm_wdata_ready, dm_grant, dm_resp_valid, dm_resp_last, dm_done;
    logic [63:0] dm_req_addr, dm_wdata, dm_resp_data;
    logic        bus_reqcyc, bus_respack, bus_respcyc, bus_reqack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;

    sysbus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_grant(if_grant),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_last(if_resp_last),
        .dm_req_valid(dm_req_valid), .dm_req_write(dm_req_write), .dm_req_addr(dm_req_addr),
        .dm_wdata(dm_wdata), .dm_wdata_ready(dm_wdata_ready), .dm_grant(dm_grant),
        .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data), .dm_resp_last(dm_resp_last),
        .dm_done(dm_done),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    typedef struct {
        logic [3:0]  in;    // {if_req_valid, dm_req_valid, bus_reqack, bus_respcyc}
        logic [63:0] resp;
        logic [9:0]  ctl;   // expected ctl_all()
        logic [12:0] tag;
        logic [63:0] req;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] ctl_all();
        return {bus_reqcyc, bus_respack, if_grant, dm_grant, if_resp_valid, dm_resp_valid,
                if_resp_last, dm_resp_last, dm_wdata_ready, dm_done};
    endfunction

    function automatic vec_t mk(logic [3:0] in, logic [63:0] resp, logic [9:0] ctl, logic [12:0] tag, logic [63:0] req);
        vec_t v;
        v.in = in; v.resp = resp; v.ctl = ctl; v.tag = tag; v.req = req;
        return v;
    endfunction

    function automatic logic [63:0] beat(logic [63:0] a, int k);
        return {a[31:0], 24'hBEEF00, 8'(k)};
    endfunction

    function automatic logic [63:0] wd(int k);
        return 64'hD0D0_0000_0000_0000 | 64'(k * 17 + 3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm, input logic [63:0] act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %h expected nothing (scoreboard empty)", nm, act);
        end else chk(nm, act, exp_q.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic wait_req(input logic [63:0] a, input logic [12:0] tag);
        int t = 0;
        @(negedge clk);
        while (!bus_reqcyc && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("req_seen", bus_reqcyc, 1);
        chk("req_addr", bus_req, a);
        chk("req_tag", bus_reqtag, tag);
    endtask

    // Serves one read line; abort < BEATS asserts reset during that beat instead of completing.
    task automatic bus_txn(input bit exp_dm, input logic [63:0] a, input bit drop, input int abort);
        wait_req(a, RD);
        bus_reqack = 1'b1;
        #1 chk("grant", {if_grant, dm_grant}, exp_dm ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        bus_reqack = 1'b0;
        if (drop) begin
            if_req_valid = 1'b0;
            dm_req_valid = 1'b0;
        end
        for (int k = 0; k < BEATS; k++) begin
            bus_respcyc = 1'b1;
            bus_resp = beat(a, k);
            if (k == abort) begin
                #2 reset = 1'b0;
                #1 chk("rst_ctl", ctl_all(), 0);
                chk("rst_req", bus_req, 0);
                chk("rst_tag", bus_reqtag, 0);
                chk("rst_data", if_resp_data | dm_resp_data, 0);
                bus_respcyc = 1'b0;
                @(posedge clk); #1;
                chk("rst_hold", ctl_all(), 0);
                reset = 1'b1;
                return;
            end
            exp_q.push_back(bus_resp);
            @(negedge clk);
            chk("rd_ctl", ctl_all(), exp_dm ? (10'h110 | (k == BEATS - 1 ? 10'h004 : 10'h000))
                                            : (10'h120 | (k == BEATS - 1 ? 10'h008 : 10'h000)));
            if (if_resp_valid || dm_resp_valid) sb_pop("rd_data", exp_dm ? dm_resp_data : if_resp_data);
            @(posedge clk); #1;
        end
        bus_respcyc = 1'b0;
    endtask

    // Data-side line write; toggle alternates reqack 1,0,1,0 starting with the request ack.
    task automatic write_txn(input bit toggle);
        int b = 0;
        int cycles = 0;
        logic ack;
        dm_req_valid = 1'b1;
        dm_req_write = 1'b1;
        dm_req_addr = 64'h2000;
        dm_wdata = wd(0);
        for (int k = 0; k < BEATS; k++) exp_q.push_back(wd(k));
        wait_req(64'h2000, WR);
        bus_reqack = 1'b1;
        #1 chk("wr_grant", {if_grant, dm_grant}, 2'b01);
        @(posedge clk); #1;
        dm_req_valid = 1'b0;
        dm_req_write = 1'b0;
        ack = !toggle;
        while (b < BEATS && cycles < 40) begin
            bus_reqack = ack;
            @(negedge clk);
            chk("wr_ready", dm_wdata_ready, ack);
            chk("wr_cyc", {bus_reqcyc, dm_done, bus_respack}, 3'b100);
            chk("wr_tag", bus_reqtag, WR);
            if (ack) sb_pop("wr_beat", bus_req);
            @(posedge clk); #1;
            cycles++;
            if (ack) begin
                b++;
                dm_wdata = wd(b);
            end
            if (toggle) ack = !ack;
        end
        bus_reqack = 1'b0;
        chk("wr_cycles", 64'(cycles), toggle ? 64'd16 : 64'd8);
        @(negedge clk);
        chk("wr_done", {dm_done, bus_reqcyc}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_done_once", {dm_done, bus_reqcyc}, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'h1000;
        dm_req_valid = 1'b0; dm_req_write = 1'b0; dm_req_addr = 64'h3000; dm_wdata = '0;
        bus_respcyc = 1'b0; bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ctl", ctl_all(), 0);
        chk("reset_req", bus_req, 0);
        chk("reset_tag", bus_reqtag, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fetch read of 0x1000: ack after 2 wait cycles, 8 beats, dead IDLE, then spurious respcyc in IDLE.
        vecs.push_back(mk(4'b1000, 0, 10'h000, 0, 0));
        vecs.push_back(mk(4'b1000, 0, 10'h200, RD, 64'h1000));
        vecs.push_back(mk(4'b1000, 0, 10'h200, RD, 64'h1000));
        vecs.push_back(mk(4'b1010, 0, 10'h280, RD, 64'h1000));
        for (int k = 0; k < BEATS; k++)
            vecs.push_back(mk(4'b0001, beat(64'h1000, k), k == BEATS - 1 ? 10'h128 : 10'h120, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 10'h000, 0, 0));
        vecs.push_back(mk(4'b0001, 64'hDEAD, 10'h000, 0, 0));
        vecs.push_back(mk(4'b0001, 64'hBEEF, 10'h000, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 10'h000, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            {if_req_valid, dm_req_valid, bus_reqack, bus_respcyc} = vecs[i].in;
            bus_resp = vecs[i].resp;
            if (vecs[i].ctl[5] || vecs[i].ctl[4]) exp_q.push_back(vecs[i].resp);
            @(negedge clk);
            chk($sformatf("v%0d_ctl", i), ctl_all(), vecs[i].ctl);
            chk($sformatf("v%0d_tag", i), bus_reqtag, vecs[i].tag);
            chk($sformatf("v%0d_req", i), bus_req, vecs[i].req);
            if (if_resp_valid || dm_resp_valid) sb_pop($sformatf("v%0d_data", i), if_resp_valid ? if_resp_data : dm_resp_data);
            @(posedge clk); #1;
        end
        {if_req_valid, dm_req_valid, bus_reqack, bus_respcyc} = 4'b0000;

        // Contention after reset: data first, then strict alternation while both stay valid.
        do_reset();
        if_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        bus_txn(1, 64'h3000, 0, BEATS);
        bus_txn(0, 64'h1000, 0, BEATS);
        bus_txn(1, 64'h3000, 0, BEATS);
        bus_txn(0, 64'h1000, 1, BEATS);

        write_txn(0);
        write_txn(1);

        // Reset during beat 3 of a fetch read, then a clean fetch read.
        do_reset();
        if_req_valid = 1'b1;
        bus_txn(0, 64'h1000, 1, 3);
        if_req_valid = 1'b1;
        bus_txn(0, 64'h1000, 1, BEATS);
        chk("sb_drain", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
